// File: rtl/arbitro_pkg.sv
// rtl/arbitro_pkg.sv - shared types and constants for the 4-source bus arbiter
package arbitro_pkg;

    typedef enum logic {
        IDLE,
        SERVE
    } estado_t;

    localparam int N_FUENTES = 4;

    typedef logic [1:0] sel_t;

endpackage

// File: rtl/prio_rr4.sv
// rtl/prio_rr4.sv - rotating (or fixed under ARB_PRIO_FIJA_EN) 4-input priority encoder
module prio_rr4
    import arbitro_pkg::*;
(
    input  logic [N_FUENTES-1:0] req,
    input  sel_t                 ultimo,
    output sel_t                 ganador,
    output logic                 hay_req
);

`ifdef ARB_PRIO_FIJA_EN
    // ultimo has no meaning with fixed priority; kept only for a uniform port list
    logic unused_ultimo;
    assign unused_ultimo = ^ultimo;

    // Source 0 highest: scan from lowest priority so the highest hit is written last
    always_comb begin
        hay_req = |req;
        ganador = '0;
        for (int i = N_FUENTES - 1; i >= 0; i--) begin
            if (req[i]) begin
                ganador = sel_t'(i);
            end
        end
    end
`else
    // Candidates ultimo+4 (lowest) down to ultimo+1 (highest); last hit wins
    always_comb begin
        sel_t cand;
        hay_req = |req;
        ganador = '0;
        cand    = '0;
        for (int k = N_FUENTES; k >= 1; k--) begin
            cand = ultimo + sel_t'(k);
            if (req[cand]) begin
                ganador = cand;
            end
        end
    end
`endif

endmodule

// File: rtl/arbitro_bus4_rr.sv
// rtl/arbitro_bus4_rr.sv - 4:1 bus arbiter with bursts, round-robin unless ARB_PRIO_FIJA_EN
module arbitro_bus4_rr
    import arbitro_pkg::*;
#(
    parameter int ANCHO      = 8,
    parameter int MAX_RAFAGA = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_FUENTES-1:0] req,
    input  logic [ANCHO-1:0]     D0,
    input  logic [ANCHO-1:0]     D1,
    input  logic [ANCHO-1:0]     D2,
    input  logic [ANCHO-1:0]     D3,
    input  logic                 ready,
    output logic [ANCHO-1:0]     Q,
    output logic                 valid,
    output logic [N_FUENTES-1:0] ack,
    output sel_t                 S,
    output logic                 busy
);

    localparam int CW = $clog2(MAX_RAFAGA + 1);
    localparam logic [CW-1:0] ULTIMO_BEAT = CW'(MAX_RAFAGA - 1);

    estado_t         estado_q, estado_n;
    sel_t            s_q, s_n;
    sel_t            ultimo_q, ultimo_n;
    logic [CW-1:0]   cuenta_q, cuenta_n;
    sel_t            ganador;
    logic            hay_req;
    logic [ANCHO-1:0] dato_sel;

    prio_rr4 u_prio (
        .req     (req),
        .ultimo  (ultimo_q),
        .ganador (ganador),
        .hay_req (hay_req)
    );

    // State registers; ultimo resets to 3 so source 0 wins the first arbitration
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= IDLE;
            s_q      <= '0;
            ultimo_q <= sel_t'(3);
            cuenta_q <= '0;
        end else begin
            estado_q <= estado_n;
            s_q      <= s_n;
            ultimo_q <= ultimo_n;
            cuenta_q <= cuenta_n;
        end
    end

    // Next-state and handshake: a burst ends on withdrawal or on its last accepted beat
    always_comb begin
        estado_n = estado_q;
        s_n      = s_q;
        ultimo_n = ultimo_q;
        cuenta_n = cuenta_q;
        valid    = 1'b0;
        ack      = '0;
        case (estado_q)
            IDLE: begin
                if (hay_req) begin
                    s_n      = ganador;
                    ultimo_n = ganador;
                    cuenta_n = '0;
                    estado_n = SERVE;
                end
            end
            SERVE: begin
                valid = req[s_q];
                if (!req[s_q]) begin
                    estado_n = IDLE;
                end else if (ready) begin
                    ack[s_q] = 1'b1;
                    cuenta_n = cuenta_q + CW'(1);
                    if (cuenta_q == ULTIMO_BEAT) begin
                        estado_n = IDLE;
                    end
                end
            end
            default: begin
                estado_n = IDLE;
            end
        endcase
    end

    // Bus mux on the registered select, zeroed whenever no beat is offered
    always_comb begin
        case (s_q)
            2'd0:    dato_sel = D0;
            2'd1:    dato_sel = D1;
            2'd2:    dato_sel = D2;
            default: dato_sel = D3;
        endcase
        Q = valid ? dato_sel : '0;
    end

    assign S    = s_q;
    assign busy = (estado_q == SERVE);

endmodule

// File: tb/tb_arbitro_bus4_rr.sv
// tb/tb_arbitro_bus4_rr.sv - directed self-checking bench for arbitro_bus4_rr
`timescale 1ns/1ps
module tb_arbitro_bus4_rr;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [7:0] D0, D1, D2, D3;
    logic       ready;
    logic [7:0] Q;
    logic       valid;
    logic [3:0] ack;
    logic [1:0] S;
    logic       busy;

    int checks = 0;
    int failures = 0;

    arbitro_bus4_rr #(.ANCHO(8), .MAX_RAFAGA(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .D0    (D0),
        .D1    (D1),
        .D2    (D2),
        .D3    (D3),
        .ready (ready),
        .Q     (Q),
        .valid (valid),
        .ack   (ack),
        .S     (S),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = 4'b0000;
        ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req = 4'b0000; ready = 1'b0;
        D0 = 8'h00; D1 = 8'h00; D2 = 8'h00; D3 = 8'h00;
        #2;
        checks++;
        if ({valid, busy, S, ack, Q} !== 16'h0000) begin
            failures++;
            $display("FAIL reset_in valid=%b busy=%b S=%0d ack=%b Q=%h expected all zero", valid, busy, S, ack, Q);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || S !== 2'd0 || busy !== 1'b0 || Q !== 8'h00) begin
                failures++;
                $display("FAIL reset_idle c=%0d valid=%b S=%0d busy=%b Q=%h expected 0 0 0 00", c, valid, S, busy, Q);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100; D2 = 8'h3C; ready = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0) begin
            failures++;
            $display("FAIL single_idle busy=%b valid=%b expected 0 0", busy, valid);
        end
        tick();
        for (int b = 0; b < 4; b++) begin
            #1;
            checks++;
            if (S !== 2'd2 || valid !== 1'b1 || Q !== 8'h3C || ack !== 4'b0100) begin
                failures++;
                $display("FAIL single_beat b=%0d S=%0d valid=%b Q=%h ack=%b expected 2 1 3c 0100", b, S, valid, Q, ack);
            end
            tick();
        end
        #1;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || ack !== 4'b0000) begin
            failures++;
            $display("FAIL single_gap busy=%b valid=%b ack=%b expected 0 0 0000", busy, valid, ack);
        end
        tick();
        #1;
        checks++;
        if (S !== 2'd2 || busy !== 1'b1) begin
            failures++;
            $display("FAIL single_regrant S=%0d busy=%b expected 2 1", S, busy);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_round_robin();
        logic [7:0] dexp;
        do_reset();
        D0 = 8'h11; D1 = 8'h22; D2 = 8'h33; D3 = 8'h44;
        req = 4'b1111; ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1;
            checks++;
            if (busy !== 1'b0) begin
                failures++;
                $display("FAIL rr_gap g=%0d busy=%b expected 0", g, busy);
            end
            tick();
            dexp = 8'h11 * 8'((g % 4) + 1);
            for (int b = 0; b < 4; b++) begin
                #1;
                checks++;
                if (S !== 2'(g % 4) || ack !== (4'b0001 << (g % 4)) || Q !== dexp) begin
                    failures++;
                    $display("FAIL rr_beat g=%0d b=%0d S=%0d ack=%b Q=%h expected S=%0d Q=%h", g, b, S, ack, Q, g % 4, dexp);
                end
                tick();
            end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        int n_ack;
        do_reset();
        req = 4'b0010; D1 = 8'h5A; ready = 1'b1;
        tick();
        n_ack = 0;
        #1;
        checks++;
        if (S !== 2'd1) begin
            failures++;
            $display("FAIL bp_grant S=%0d expected 1", S);
        end
        if (ack === 4'b0010) n_ack++;
        tick();
        ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (valid !== 1'b1 || Q !== 8'h5A || ack !== 4'b0000 || busy !== 1'b1) begin
                failures++;
                $display("FAIL bp_hold c=%0d valid=%b Q=%h ack=%b busy=%b expected 1 5a 0000 1", c, valid, Q, ack, busy);
            end
            tick();
        end
        ready = 1'b1;
        for (int k = 0; k < 10 && busy; k++) begin
            #1;
            if (ack === 4'b0010) n_ack++;
            tick();
        end
        checks++;
        if (busy !== 1'b0 || n_ack !== 4) begin
            failures++;
            $display("FAIL bp_total busy=%b acks=%0d expected 0 4", busy, n_ack);
        end
        req = 4'b0000;
    endtask

    task automatic test_withdraw();
        do_reset();
        req = 4'b0001; D0 = 8'hA5; ready = 1'b1;
        tick();
        for (int b = 0; b < 2; b++) begin
            #1;
            checks++;
            if (ack !== 4'b0001 || Q !== 8'hA5) begin
                failures++;
                $display("FAIL wd_beat b=%0d ack=%b Q=%h expected 0001 a5", b, ack, Q);
            end
            tick();
        end
        req = 4'b0000;
        #1;
        checks++;
        if (valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wd_drop valid=%b ack=%b busy=%b expected 0 0000 1", valid, ack, busy);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL wd_idle busy=%b expected 0", busy);
        end
        req = 4'b1001;
        tick();
        checks++;
        if (S !== 2'd3 || busy !== 1'b1) begin
            failures++;
            $display("FAIL wd_next S=%0d busy=%b expected 3 1", S, busy);
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b0100; D2 = 8'h3C; ready = 1'b1;
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || ack !== 4'b0100) begin
            failures++;
            $display("FAIL rm_beat2 valid=%b ack=%b expected 1 0100", valid, ack);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || ack !== 4'b0000 || busy !== 1'b0 || S !== 2'd0 || Q !== 8'h00) begin
            failures++;
            $display("FAIL rm_async valid=%b ack=%b busy=%b S=%0d Q=%h expected all zero", valid, ack, busy, S, Q);
        end
        req = 4'b1111;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        checks++;
        if (S !== 2'd0 || busy !== 1'b1 || ack !== 4'b0001) begin
            failures++;
            $display("FAIL rm_first S=%0d busy=%b ack=%b expected 0 1 0001", S, busy, ack);
        end
        req = 4'b0000;
        tick();
    endtask

`ifdef ARB_PRIO_FIJA_EN
    task automatic test_fixed();
        do_reset();
        req = 4'b1111; ready = 1'b1;
        for (int g = 0; g < 3; g++) begin
            tick();
            checks++;
            if (S !== 2'd0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL fixed_grant g=%0d S=%0d busy=%b expected 0 1", g, S, busy);
            end
            repeat (4) tick();
        end
        req = 4'b0000;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_reset_mid();
`ifdef ARB_PRIO_FIJA_EN
        test_fixed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
